// File: rtl/spi_tx_ctrl_pkg.sv
// Shared SPI definitions: frame geometry, FSM state encoding and divider helper.
package spi_tx_ctrl_pkg;

   localparam int unsigned FRAME_BITS = 16;
   localparam int unsigned EDGE_COUNT = 2 * FRAME_BITS;
   localparam int unsigned DIV_W      = 10;
   localparam int unsigned EDGE_W     = 6;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StShift,
      StHold
   } state_e;

   // A zero half-period would never let the counter expire cleanly; treat it as 1.
   function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
      logic [DIV_W-1:0] one;
      one = {{(DIV_W-1){1'b0}}, 1'b1};
      return (d == '0) ? one : d;
   endfunction

endpackage

// File: rtl/spi_tx_ctrl.sv
// SPI mode-0 frame controller: shifts one 16-bit word out on MOSI while capturing MISO.
// Timing comes from an external half-period counter driven through cnt_en/cnt_clr.
module spi_tx_ctrl
   import spi_tx_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [FRAME_BITS-1:0] tx_data,
   input  logic [DIV_W-1:0]      div,
   input  logic [DIV_W-1:0]      cuenta,
   input  logic                  miso,
   output logic                  cnt_en,
   output logic                  cnt_clr,
   output logic                  sclk,
   output logic                  mosi,
   output logic                  cs_n,
   output logic                  busy,
   output logic                  done,
   output logic [FRAME_BITS-1:0] rx_data
);

   state_e                state_q, state_d;
   logic [FRAME_BITS-1:0] tx_sr_q, tx_sr_d;
   logic [FRAME_BITS-1:0] rx_sr_q, rx_sr_d;
   logic [FRAME_BITS-1:0] rx_word_q, rx_word_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic [EDGE_W-1:0]     edge_q, edge_d;
   logic                  sclk_q, sclk_d;
   logic                  active;
   logic                  tick;
   logic                  last_edge;

   assign active    = (state_q != StIdle);
   assign tick      = active && (cuenta >= div_q);
   assign last_edge = (edge_q == EDGE_W'(EDGE_COUNT - 1));

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         tx_sr_q   <= '0;
         rx_sr_q   <= '0;
         rx_word_q <= '0;
         div_q     <= '0;
         edge_q    <= '0;
         sclk_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tx_sr_q   <= tx_sr_d;
         rx_sr_q   <= rx_sr_d;
         rx_word_q <= rx_word_d;
         div_q     <= div_d;
         edge_q    <= edge_d;
         sclk_q    <= sclk_d;
      end
   end

   // Next-state logic, shift-register updates and decoded outputs.
   always_comb begin
      state_d   = state_q;
      tx_sr_d   = tx_sr_q;
      rx_sr_d   = rx_sr_q;
      rx_word_d = rx_word_q;
      div_d     = div_q;
      edge_d    = edge_q;
      sclk_d    = sclk_q;
      done      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StSetup;
               tx_sr_d = tx_data;
               rx_sr_d = '0;
               div_d   = eff_div(div);
               edge_d  = '0;
               sclk_d  = 1'b0;
            end
         end
         StSetup: begin
            if (tick) begin
               state_d = StShift;
            end
         end
         StShift: begin
            if (tick) begin
               sclk_d = ~sclk_q;
               edge_d = edge_q + EDGE_W'(1);
               if (!sclk_q) begin
                  // Rising edge: sample the slave's bit.
                  rx_sr_d = {rx_sr_q[FRAME_BITS-2:0], miso};
               end else if (!last_edge) begin
                  // Falling edge: present the next bit; the final one stays on the line.
                  tx_sr_d = {tx_sr_q[FRAME_BITS-2:0], 1'b0};
               end
               if (last_edge) begin
                  state_d = StHold;
               end
            end
         end
         StHold: begin
            if (tick) begin
               state_d   = StIdle;
               done      = 1'b1;
               rx_word_d = rx_sr_q;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Counter stays cleared while idle so every frame starts from zero.
   assign cnt_en  = active;
   assign cnt_clr = !active || tick;
   assign busy    = active;
   assign cs_n    = !active;
   assign sclk    = sclk_q;
   assign mosi    = active ? tx_sr_q[FRAME_BITS-1] : 1'b0;
   // Present the fresh word during the done pulse; the register holds it afterwards.
   assign rx_data = done ? rx_sr_q : rx_word_q;

endmodule

// File: tb/tb_spi_tx_ctrl.sv
// Bench for spi_tx_ctrl: models the external half-period counter, drives directed
// frames and checks each completed frame against a queue of expected results.
module tb_spi_tx_ctrl;
   import spi_tx_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] tx_data = '0;
   logic [9:0]  div = '0;
   logic [9:0]  cuenta = '0;
   logic        miso;
   logic        miso_inv = 1'b0;
   logic        cnt_en, cnt_clr, sclk, mosi, cs_n, busy, done;
   logic [15:0] rx_data;

   int checks = 0;
   int errors = 0;
   int unsigned cyc = 0;
   int unsigned done_cnt = 0;

   typedef struct {
      logic [15:0] rx;
      logic [15:0] mosi_word;
      int unsigned deff;
   } exp_t;
   exp_t exp_q[$];

   spi_tx_ctrl dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .tx_data (tx_data),
      .div     (div),
      .cuenta  (cuenta),
      .miso    (miso),
      .cnt_en  (cnt_en),
      .cnt_clr (cnt_clr),
      .sclk    (sclk),
      .mosi    (mosi),
      .cs_n    (cs_n),
      .busy    (busy),
      .done    (done),
      .rx_data (rx_data)
   );

   always #5 clk = ~clk;

   // External 10-bit half-period counter with synchronous clear.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cnt_clr) cuenta <= '0;
      else if (cnt_en) cuenta <= cuenta + 10'd1;
   end

   assign miso = miso_inv ? ~mosi : mosi;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic check_near(input string name, input int unsigned act, input int unsigned req);
      checks++;
      if (act + 1 < req || act > req + 1) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d +/-1", name, act, req);
      end
   endtask

   // Monitor: per-frame observation, compared against the scoreboard on done.
   logic        sclk_prev = 1'b0;
   logic        done_prev = 1'b0;
   logic        busy_prev = 1'b0;
   int unsigned f_start = 0;
   int unsigned edges = 0;
   int unsigned cs_low = 0;
   logic [15:0] mword = '0;
   logic [9:0]  cmax = '0;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         edges  = 0;
         cs_low = 0;
         mword  = '0;
         cmax   = '0;
      end else begin
         if (busy && !busy_prev) begin
            f_start = cyc;
            edges   = 0;
            cs_low  = 0;
            mword   = '0;
            cmax    = '0;
         end
         if (busy) begin
            if (!cs_n) cs_low++;
            if (cuenta > cmax) cmax = cuenta;
         end
         if (sclk != sclk_prev) begin
            edges++;
            if (sclk) mword = {mword[14:0], mosi};
         end
         if (done) begin
            done_cnt++;
            check("done_single_cycle", 32'(done_prev), 32'd0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done with rx_data 0x%0h, expected none", rx_data);
            end else begin
               e = exp_q.pop_front();
               check("rx_data", 32'(rx_data), 32'(e.rx));
               check("mosi_sequence", 32'(mword), 32'(e.mosi_word));
               check("sclk_edges", edges, 32'd32);
               check("cnt_peak", 32'(cmax), e.deff);
               check_near("frame_len", cyc - f_start + 1, 34 * (e.deff + 1));
               check_near("cs_low_len", cs_low, 34 * (e.deff + 1));
            end
         end
      end
      sclk_prev = sclk;
      done_prev = done;
      busy_prev = busy;
   end

   task automatic issue(input logic [15:0] d, input logic [9:0] dv, input logic inv,
                        input logic expect_done);
      exp_t e;
      @(negedge clk);
      while (busy) @(negedge clk);
      tx_data  = d;
      div      = dv;
      miso_inv = inv;
      start    = 1'b1;
      if (expect_done) begin
         e.rx        = inv ? ~d : d;
         e.mosi_word = d;
         e.deff      = (dv == 10'd0) ? 1 : 32'(dv);
         exp_q.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int unsigned budget);
      int unsigned n = 0;
      while (!done && n < budget) begin
         @(posedge clk);
         #2;
         n++;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL done_timeout: got no done within %0d cycles, expected a pulse", budget);
      end
   endtask

   task automatic wait_edges(input int unsigned k);
      int unsigned n = 0;
      while (edges < k && n < 5000) begin
         @(posedge clk);
         #2;
         n++;
      end
      check("edge_wait", 32'(edges >= k), 32'd1);
   endtask

   initial begin
      exp_t e;
      int unsigned saved;

      // Reset state.
      repeat (3) @(posedge clk);
      #2;
      check("rst_cs_n", 32'(cs_n), 32'd1);
      check("rst_sclk", 32'(sclk), 32'd0);
      check("rst_mosi", 32'(mosi), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_cnt_en", 32'(cnt_en), 32'd0);
      check("rst_cnt_clr", 32'(cnt_clr), 32'd1);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Loopback frame, div=4.
      issue(16'hA5C3, 10'd4, 1'b0, 1'b1);
      wait_done(34 * 5 + 100);

      // div=0 runs as div=1; inverted MISO gives a complemented word.
      issue(16'h3C96, 10'd0, 1'b1, 1'b1);
      wait_done(34 * 2 + 100);

      // Start and new data/div mid-SHIFT are ignored.
      issue(16'h0F0F, 10'd3, 1'b0, 1'b1);
      wait_edges(6);
      @(negedge clk);
      tx_data = 16'hFFFF;
      div     = 10'd7;
      start   = 1'b1;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_done(34 * 4 + 100);
      repeat (100) @(posedge clk);
      #2;
      check("no_queued_start", 32'(busy), 32'd0);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      // Start held through done: not taken in the done cycle, taken on the next IDLE cycle.
      @(negedge clk);
      while (busy) @(negedge clk);
      tx_data  = 16'h1234;
      div      = 10'd2;
      miso_inv = 1'b0;
      start    = 1'b1;
      e.rx = 16'h1234;
      e.mosi_word = 16'h1234;
      e.deff = 2;
      exp_q.push_back(e);
      exp_q.push_back(e);
      wait_done(34 * 3 + 100);
      @(posedge clk);
      #2;
      check("idle_after_done", 32'(busy), 32'd0);
      @(posedge clk);
      #2;
      check("restart_after_done", 32'(busy), 32'd1);
      start = 1'b0;
      wait_done(34 * 3 + 100);

      // Reset after 10 sclk edges aborts the frame without done.
      issue(16'hBEEF, 10'd3, 1'b0, 1'b0);
      wait_edges(10);
      saved = done_cnt;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #2;
      check("abort_cs_n", 32'(cs_n), 32'd1);
      check("abort_sclk", 32'(sclk), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_rx_data", 32'(rx_data), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (200) @(posedge clk);
      #2;
      check("abort_no_done", done_cnt, saved);

      // Full frame after abort.
      issue(16'h8001, 10'd5, 1'b0, 1'b1);
      wait_done(34 * 6 + 100);

      // Maximum divider: counter reaches 1023 without wrapping.
      issue(16'h6E19, 10'd1023, 1'b0, 1'b1);
      wait_done(34 * 1024 + 200);

      repeat (10) @(posedge clk);
      #2;
      check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
